fsm_vedacao: RTL and testbench

- Moore FSM for the capping stage of the bottling line. It sits directly upstream of the quality-control stage.
- On a command from the Mestre it waits for the bottle at the capping position and drives the capping actuator for a fixed time. It then reports completion.
- Owns the cork-stock counter: decrements one cork per capping and adds a batch on each operator refill pulse.
- Raises an alarm and stalls while the stock is empty.

---
 rtl/fsm_vedacao_pkg.sv | 25 ++
 rtl/fsm_vedacao_contador_estoque_rolhas.sv | 49 ++++
 rtl/fsm_vedacao.sv | 144 ++++++++++++++
 tb/tb_fsm_vedacao.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fsm_vedacao_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : fsm_vedacao_pkg                                              |
// | Description : State encodings, 50 MHz time constants, default stock values |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fsm_vedacao_pkg;

    localparam int c_T_VEDACAO_50M   = 25_000_000;
    localparam int c_T_TIMEOUT_50M   = 250_000_000;
    localparam int c_ESTOQUE_W       = 7;
    localparam int c_ESTOQUE_MAX     = 100;
    localparam int c_ESTOQUE_INICIAL = 20;
    localparam int c_REPOSICAO       = 20;

    localparam int c_STATE_W = 3;
    localparam logic [c_STATE_W-1:0] c_IDLE            = 3'd0;
    localparam logic [c_STATE_W-1:0] c_AGUARDA_POSICAO = 3'd1;
    localparam logic [c_STATE_W-1:0] c_VEDANDO         = 3'd2;
    localparam logic [c_STATE_W-1:0] c_CONCLUIDO       = 3'd3;
    localparam logic [c_STATE_W-1:0] c_SEM_ROLHA       = 3'd4;
    localparam logic [c_STATE_W-1:0] c_ERRO_POSICAO    = 3'd5;

endpackage
`default_nettype wire

// File: rtl/fsm_vedacao_contador_estoque_rolhas.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : contador_estoque_rolhas                                      |
// | Description : Saturating cork-stock counter, one-cork decrement + refill   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module contador_estoque_rolhas
    import fsm_vedacao_pkg::*;
#(
    parameter int ESTOQUE_W       = c_ESTOQUE_W,
    parameter int ESTOQUE_MAX     = c_ESTOQUE_MAX,
    parameter int ESTOQUE_INICIAL = c_ESTOQUE_INICIAL,
    parameter int REPOSICAO       = c_REPOSICAO
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dec,
    input  logic                 rep,
    output logic [ESTOQUE_W-1:0] estoque
);

    localparam logic [ESTOQUE_W:0]   c_MAX = (ESTOQUE_W+1)'(ESTOQUE_MAX);
    localparam logic [ESTOQUE_W:0]   c_REP = (ESTOQUE_W+1)'(REPOSICAO);
    localparam logic [ESTOQUE_W-1:0] c_INI = ESTOQUE_W'(ESTOQUE_INICIAL);

    logic [ESTOQUE_W-1:0] r_estoque;
    logic [ESTOQUE_W:0]   w_soma;
    logic [ESTOQUE_W-1:0] w_prox;
    logic                 w_dec;

    // One extra bit keeps refill on a near-full stock from wrapping before saturation
    always_comb begin
        w_dec  = dec && (r_estoque != '0);
        w_soma = {1'b0, r_estoque} - {{ESTOQUE_W{1'b0}}, w_dec} + (rep ? c_REP : '0);
        w_prox = (w_soma > c_MAX) ? c_MAX[ESTOQUE_W-1:0] : w_soma[ESTOQUE_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estoque <= c_INI;
        end else begin
            r_estoque <= w_prox;
        end
    end

    assign estoque = r_estoque;

endmodule
`default_nettype wire

// File: rtl/fsm_vedacao.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fsm_vedacao                                                  |
// | Description : Moore FSM for the capping stage; owns the cork stock.        |
// |               VEDACAO_TIMEOUT_EN adds the position-wait timeout state.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fsm_vedacao
    import fsm_vedacao_pkg::*;
#(
    parameter int T_VEDACAO       = c_T_VEDACAO_50M,
    parameter int ESTOQUE_W       = c_ESTOQUE_W,
    parameter int ESTOQUE_MAX     = c_ESTOQUE_MAX,
    parameter int ESTOQUE_INICIAL = c_ESTOQUE_INICIAL,
    parameter int REPOSICAO       = c_REPOSICAO,
    parameter int T_TIMEOUT       = c_T_TIMEOUT_50M
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_vedar,
    input  logic                 sensor_vedacao,
    input  logic                 pulso_reposicao,
    output logic                 atuador_vedacao,
    output logic                 tarefa_concluida,
    output logic                 alarme_sem_rolha,
    output logic                 erro_posicao,
    output logic [ESTOQUE_W-1:0] estoque_rolhas
);

    localparam int c_TV_W = $clog2(T_VEDACAO + 1);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next;
    logic [c_TV_W-1:0]    r_timer;
    logic                 w_dec;
    logic                 w_tem_rolha;
    logic                 w_fim_vedacao;

    assign w_tem_rolha   = (estoque_rolhas != '0);
    assign w_fim_vedacao = (r_timer == c_TV_W'(T_VEDACAO - 1));

`ifdef VEDACAO_TIMEOUT_EN
    localparam int c_TO_W = $clog2(T_TIMEOUT + 1);

    logic [c_TO_W-1:0] r_t_pos;
    logic              w_expirou;

    assign w_expirou = (r_t_pos == c_TO_W'(T_TIMEOUT - 1));

    // Cleared whenever outside AGUARDA_POSICAO, so every entry starts from zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_t_pos <= '0;
        end else if (r_state == c_AGUARDA_POSICAO) begin
            r_t_pos <= r_t_pos + 1'b1;
        end else begin
            r_t_pos <= '0;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (T_TIMEOUT == 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (r_state == c_VEDANDO) begin
            r_timer <= r_timer + 1'b1;
        end else begin
            r_timer <= '0;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (cmd_vedar) w_next = c_AGUARDA_POSICAO;
            end
            c_AGUARDA_POSICAO: begin
                if (!cmd_vedar)                       w_next = c_IDLE;
                else if (sensor_vedacao && w_tem_rolha) w_next = c_VEDANDO;
                else if (sensor_vedacao)              w_next = c_SEM_ROLHA;
`ifdef VEDACAO_TIMEOUT_EN
                else if (w_expirou)                   w_next = c_ERRO_POSICAO;
`endif
            end
            c_SEM_ROLHA: begin
                if (!cmd_vedar)       w_next = c_IDLE;
                else if (w_tem_rolha) w_next = c_VEDANDO;
            end
            c_VEDANDO: begin
                if (w_fim_vedacao) w_next = c_CONCLUIDO;
            end
            c_CONCLUIDO: begin
                if (!cmd_vedar) w_next = c_IDLE;
            end
`ifdef VEDACAO_TIMEOUT_EN
            c_ERRO_POSICAO: begin
                if (!cmd_vedar) w_next = c_IDLE;
            end
`endif
            default: w_next = c_IDLE;
        endcase
    end

    // A cork is consumed on the edge that enters VEDANDO
    assign w_dec = (w_next == c_VEDANDO) && (r_state != c_VEDANDO);

    always_comb begin
        atuador_vedacao  = (r_state == c_VEDANDO);
        tarefa_concluida = (r_state == c_CONCLUIDO);
        alarme_sem_rolha = (r_state == c_SEM_ROLHA);
`ifdef VEDACAO_TIMEOUT_EN
        erro_posicao     = (r_state == c_ERRO_POSICAO);
`else
        erro_posicao     = 1'b0;
`endif
    end

    contador_estoque_rolhas #(
        .ESTOQUE_W       (ESTOQUE_W),
        .ESTOQUE_MAX     (ESTOQUE_MAX),
        .ESTOQUE_INICIAL (ESTOQUE_INICIAL),
        .REPOSICAO       (REPOSICAO)
    ) u_estoque (
        .clk     (clk),
        .reset   (reset),
        .dec     (w_dec),
        .rep     (pulso_reposicao),
        .estoque (estoque_rolhas)
    );

endmodule
`default_nettype wire

// File: tb/tb_fsm_vedacao.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fsm_vedacao                                               |
// | Description : Randomized scoreboard bench for fsm_vedacao                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fsm_vedacao;

    localparam int T_V  = 4;
    localparam int INI  = 2;
    localparam int REP  = 3;
    localparam int MAXS = 5;
    localparam int T_TO = 8;
    localparam int W    = 7;
    localparam int N_CYCLES = 3000;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd = 1'b0;
    logic         sens = 1'b0;
    logic         pulse = 1'b0;
    logic         at, tc, al, er;
    logic [W-1:0] est;

    always #5 clk = ~clk;

    fsm_vedacao #(
        .T_VEDACAO       (T_V),
        .ESTOQUE_W       (W),
        .ESTOQUE_MAX     (MAXS),
        .ESTOQUE_INICIAL (INI),
        .REPOSICAO       (REP),
        .T_TIMEOUT       (T_TO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_vedar        (cmd),
        .sensor_vedacao   (sens),
        .pulso_reposicao  (pulse),
        .atuador_vedacao  (at),
        .tarefa_concluida (tc),
        .alarme_sem_rolha (al),
        .erro_posicao     (er),
        .estoque_rolhas   (est)
    );

    typedef struct packed {
        logic         at;
        logic         tc;
        logic         al;
        logic         er;
        logic [W-1:0] est;
    } exp_t;

    typedef enum int {M_IDLE, M_WAIT, M_EMPTY, M_ACT, M_DONE, M_ERR} mphase_t;

    exp_t    q[$];
    int      n_cmp = 0;
    int      n_err = 0;
    mphase_t ph;
    int      stock;
    int      remaining;
    int      waited;

    function automatic exp_t expected();
        exp_t e;
        e.at  = (ph == M_ACT);
        e.tc  = (ph == M_DONE);
        e.al  = (ph == M_EMPTY);
        e.er  = (ph == M_ERR);
        e.est = W'(stock);
        return e;
    endfunction

    task automatic model_reset();
        ph = M_IDLE; stock = INI; remaining = 0; waited = 0;
    endtask

    // Behavioural reference: one call per rising edge with the inputs seen on it
    task automatic model_step(input logic c, input logic s, input logic p);
        int used = 0;
        case (ph)
            M_IDLE:  if (c) begin ph = M_WAIT; waited = 0; end
            M_WAIT: begin
                if (!c) ph = M_IDLE;
                else if (s && stock > 0) begin ph = M_ACT; used = 1; remaining = T_V; end
                else if (s) ph = M_EMPTY;
`ifdef VEDACAO_TIMEOUT_EN
                else begin
                    waited++;
                    if (waited >= T_TO) ph = M_ERR;
                end
`endif
            end
            M_EMPTY: begin
                if (!c) ph = M_IDLE;
                else if (stock > 0) begin ph = M_ACT; used = 1; remaining = T_V; end
            end
            M_ACT: begin
                remaining--;
                if (remaining == 0) ph = M_DONE;
            end
            M_DONE, M_ERR: if (!c) ph = M_IDLE;
            default: ph = M_IDLE;
        endcase
        stock = stock - used + (p ? REP : 0);
        if (stock > MAXS) stock = MAXS;
    endtask

    task automatic check(input string name, input exp_t act, input exp_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got at=%b tc=%b al=%b er=%b est=%0d, expected at=%b tc=%b al=%b er=%b est=%0d",
                     name, $time, act.at, act.tc, act.al, act.er, act.est,
                     exp.at, exp.tc, exp.al, exp.er, exp.est);
        end
    endtask

    function automatic exp_t observed();
        exp_t o;
        o.at = at; o.tc = tc; o.al = al; o.er = er; o.est = est;
        return o;
    endfunction

    // Monitor: pops one expectation per cycle, sampled on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) check("cycle", observed(), q.pop_front());
        end
    end

    initial begin
        bit did_reset = 0;
        int seg;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check("reset_state", observed(), expected());
        @(posedge clk);
        #2 reset = 1'b0;

        for (int i = 0; i < N_CYCLES; i++) begin
            seg = i / 500;
            if (!did_reset && i >= 1500 && ph == M_ACT) begin
                reset = 1'b1;
                q.delete();
                model_reset();
                #1 check("async_reset", observed(), expected());
                @(posedge clk);
                q.push_back(expected());
                #2 reset = 1'b0;
                did_reset = 1;
            end
            if (cmd) begin
                if (ph == M_DONE || ph == M_ERR) cmd = ($urandom_range(0, 1) == 0);
                else                             cmd = ($urandom_range(0, 99) >= 3);
            end else begin
                cmd = ($urandom_range(0, 99) < 30);
            end
            sens  = (seg == 2) ? ($urandom_range(0, 99) < 3) : ($urandom_range(0, 99) < 35);
            pulse = (seg == 3) ? ($urandom_range(0, 99) < 25) : ($urandom_range(0, 99) < 6);
            @(posedge clk);
            model_step(cmd, sens, pulse);
            q.push_back(expected());
            #2;
        end

        if (!did_reset) begin
            n_cmp++;
            n_err++;
            $display("FAIL async_reset: never reached actuation after cycle 1500, got 0 resets, required 1");
        end

        cmd = 1'b0; sens = 1'b0; pulse = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: got %0d pending, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
